// File: rtl/tetris_pkg.sv
// Shared types for the matrix-memory executors and the write-port arbiter.
package tetris;

    // Board coordinate: 5 bits per axis covers a 10x20 playfield with margin.
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } point_t;

    // 4x4 cell mask carried by every executor write transaction.
    typedef logic [3:0][3:0] cell_mask_t;

    // Write-port arbiter states.
    typedef enum logic [1:0] {
        eIDLE,
        eWrite,
        eWait,
        eDone
    } mm_write_arb_state_e;

endpackage

// File: rtl/mm_write_arbiter_rr.sv
// Combinational round-robin pick: the search starts just after the last winner
// and wraps, so each requester waits at most num_req_p-1 turns.
module rr_arbiter #(
    parameter int unsigned num_req_p = 3,
    localparam int unsigned idx_w_lp = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [idx_w_lp-1:0]  last_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [idx_w_lp-1:0]  idx_o,
    output logic                 v_o
);

    int unsigned cand;

    // Scan last+1 .. last+num_req_p modulo num_req_p; the first set bit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        v_o     = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= num_req_p; k++) begin
            cand = (32'(last_i) + k) % num_req_p;
            if (!v_o && req_i[idx_w_lp'(cand)]) begin
                v_o                      = 1'b1;
                grant_o[idx_w_lp'(cand)] = 1'b1;
                idx_o                    = idx_w_lp'(cand);
            end
        end
    end

endmodule

// File: rtl/mm_write_arbiter.sv
// Shares the single matrix-memory write port among the write executors:
// one 4x4 transaction at a time, round-robin, with a watchdog on completion.
module mm_write_arbiter
    import tetris::*;
#(
    parameter int unsigned num_req_p = 3,
    parameter int unsigned timeout_p = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic       [num_req_p-1:0]    req_v_i,
    input  point_t     [num_req_p-1:0]    req_addr_i,
    input  cell_mask_t [num_req_p-1:0]    req_data_i,
    output logic       [num_req_p-1:0]    grant_o,
    output logic       [num_req_p-1:0]    done_o,
    output logic                          busy_o,
    output logic                          timeout_o,
    output point_t                        mm_write_addr_o,
    output cell_mask_t                    mm_write_data_o,
    output logic                          mm_write_v_o,
    input  logic                          mm_is_ready_i
);

    localparam int unsigned idx_w_lp = $clog2(num_req_p);
    localparam int unsigned wd_w_lp  = $clog2(timeout_p + 1);
    // Expiry is detected in the last allowed eWait cycle so eDone lands at
    // exactly timeout_p eWait cycles.
    localparam logic [wd_w_lp-1:0] wd_last_lp = wd_w_lp'(timeout_p - 1);

    mm_write_arb_state_e   state_r, state_n;
    logic [idx_w_lp-1:0]   last_r;
    logic [idx_w_lp-1:0]   sel_r;
    point_t                addr_r;
    cell_mask_t            data_r;
    logic [wd_w_lp-1:0]    wd_cnt_r;
    logic                  timeout_r;

    logic [num_req_p-1:0]  arb_grant;
    logic [idx_w_lp-1:0]   arb_idx;
    logic                  arb_v;
    logic                  wd_expire;

    rr_arbiter #(
        .num_req_p (num_req_p)
    ) u_rr (
        .req_i   (req_v_i),
        .last_i  (last_r),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .v_o     (arb_v)
    );

    assign wd_expire = (state_r == eWait) && !mm_is_ready_i && (wd_cnt_r == wd_last_lp);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= eIDLE;
        else         state_r <= state_n;
    end

    // Next-state logic: ready is only honoured from eWait.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            eIDLE:   if (arb_v) state_n = eWrite;
            eWrite:  state_n = eWait;
            eWait:   if (mm_is_ready_i || wd_expire) state_n = eDone;
            eDone:   state_n = eIDLE;
            default: state_n = eIDLE;
        endcase
    end

    // Output decode: grant only while idle, done for the latched winner.
    always_comb begin
        grant_o      = '0;
        done_o       = '0;
        busy_o       = (state_r != eIDLE);
        mm_write_v_o = (state_r == eWrite);
        if (state_r == eIDLE) grant_o = arb_grant;
        if (state_r == eDone) done_o[sel_r] = 1'b1;
    end

    // Latch winner, address and mask on grant; they hold until the next grant.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r <= idx_w_lp'(num_req_p - 1);
            sel_r  <= '0;
            addr_r <= '0;
            data_r <= '0;
        end else if (state_r == eIDLE && arb_v) begin
            last_r <= arb_idx;
            sel_r  <= arb_idx;
            addr_r <= req_addr_i[arb_idx];
            data_r <= req_data_i[arb_idx];
        end
    end

    // Watchdog: cleared while entering eWait, counts every eWait cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i)                wd_cnt_r <= '0;
        else if (state_r == eWrite) wd_cnt_r <= '0;
        else if (state_r == eWait)  wd_cnt_r <= wd_cnt_r + 1'b1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (reset_i)        timeout_r <= 1'b0;
        else if (wd_expire) timeout_r <= 1'b1;
    end

    assign timeout_o       = timeout_r;
    assign mm_write_addr_o = addr_r;
    assign mm_write_data_o = data_r;

endmodule

// File: tb/tb_mm_write_arbiter.sv
// Scoreboard bench for mm_write_arbiter: a transaction-timing model predicts
// grant / strobe / done events into queues; a negedge monitor pops and compares.
module tb_mm_write_arbiter;
    import tetris::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 8;

    typedef struct {
        int         c;
        int         idx;
        point_t     addr;
        cell_mask_t data;
        logic       to;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic       [N-1:0]    req_v_i;
    point_t     [N-1:0]    req_addr_i;
    cell_mask_t [N-1:0]    req_data_i;
    logic       [N-1:0]    grant_o;
    logic       [N-1:0]    done_o;
    logic                  busy_o;
    logic                  timeout_o;
    point_t                mm_write_addr_o;
    cell_mask_t            mm_write_data_o;
    logic                  mm_write_v_o;
    logic                  mm_is_ready_i;

    always #5 clk = ~clk;

    mm_write_arbiter #(
        .num_req_p (N),
        .timeout_p (TO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_v_i         (req_v_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .grant_o         (grant_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o),
        .mm_write_addr_o (mm_write_addr_o),
        .mm_write_data_o (mm_write_data_o),
        .mm_write_v_o    (mm_write_v_o),
        .mm_is_ready_i   (mm_is_ready_i)
    );

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t gq[$];
    ev_t wq[$];
    ev_t dq[$];

    // Requester-side state
    logic [N-1:0] pend;
    point_t       paddr [N];
    cell_mask_t   pdata [N];
    int           gcyc  [N];

    // Reference model: a transaction granted at cycle g strobes at g+1, waits
    // from g+2, completes the cycle after ready (or after TO wait cycles).
    bit         m_busy;
    int         m_g, m_idx, m_last, m_done_c;
    bit         m_to;
    point_t     m_addr;
    cell_mask_t m_data;

    function automatic point_t rnd_addr();
        logic [31:0] r;
        r = $urandom;
        return r[9:0];
    endfunction

    function automatic cell_mask_t rnd_data();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_last   = N - 1;
        m_to     = 0;
        m_done_c = -1;
        pend     = '0;
    endtask

    task automatic model_step(input logic rdy);
        ev_t e;
        int  w;
        if (m_busy && m_done_c >= 0 && cyc > m_done_c) m_busy = 0;
        if (!m_busy) begin
            if (pend != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
                m_busy = 1; m_g = cyc; m_idx = w; m_last = w; m_done_c = -1;
                m_addr = paddr[w]; m_data = pdata[w];
                pend[w] = 1'b0; gcyc[w] = cyc;
                e = '{cyc, w, m_addr, m_data, 1'b0};
                gq.push_back(e);
                e.c = cyc + 1;
                wq.push_back(e);
            end
        end else if (m_done_c < 0 && cyc >= m_g + 2) begin
            if (rdy || (cyc - (m_g + 2) + 1 == TO)) begin
                if (!rdy) m_to = 1;
                m_done_c = cyc + 1;
                e = '{cyc + 1, m_idx, m_addr, m_data, m_to};
                dq.push_back(e);
            end
        end
    endtask

    task automatic raise(input int i, input point_t a, input cell_mask_t d);
        if (!pend[i] && gcyc[i] != cyc) begin
            pend[i]  = 1'b1;
            paddr[i] = a;
            pdata[i] = d;
        end
    endtask

    task automatic step(input logic rdy, input logic rst);
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            req_v_i[i]    = pend[i];
            req_addr_i[i] = pend[i] ? paddr[i] : rnd_addr();
            req_data_i[i] = pend[i] ? pdata[i] : rnd_data();
        end
        mm_is_ready_i = rdy;
        reset_i       = rst;
        model_step(rdy);
        if (rst) model_reset();
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", nm, cyc, got, want);
        end
    endtask

    // Reset, then verify every output sits at its reset value the next cycle.
    task automatic do_reset();
        pend = '0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        @(negedge clk);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_strobe", 32'(mm_write_v_o), 0);
        chk("rst_addr", 32'(mm_write_addr_o), 0);
        chk("rst_data", 32'(mm_write_data_o), 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 10; t++) step(1'b1, 1'b0);
    endtask

    // Monitor: each output event must coincide with the head of its queue.
    initial begin
        ev_t          e;
        logic [N-1:0] want;
        bit           exp_here;
        forever begin
            @(negedge clk);
            exp_here = gq.size() > 0 && gq[0].c == cyc;
            if (grant_o != '0 || exp_here) begin
                checks++;
                if (!exp_here) begin
                    errors++;
                    $display("FAIL grant_unexpected cyc %0d got %b want 0", cyc, grant_o);
                end else begin
                    e = gq.pop_front();
                    want = '0; want[e.idx] = 1'b1;
                    if (grant_o !== want || busy_o !== 1'b0) begin
                        errors++;
                        $display("FAIL grant cyc %0d got %b busy %b want %b busy 0", cyc, grant_o, busy_o, want);
                    end
                end
            end
            exp_here = wq.size() > 0 && wq[0].c == cyc;
            if (mm_write_v_o !== 1'b0 || exp_here) begin
                checks++;
                if (!exp_here) begin
                    errors++;
                    $display("FAIL strobe_unexpected cyc %0d got %b want 0", cyc, mm_write_v_o);
                end else begin
                    e = wq.pop_front();
                    if (mm_write_v_o !== 1'b1 || mm_write_addr_o !== e.addr ||
                        mm_write_data_o !== e.data || busy_o !== 1'b1 || grant_o !== '0) begin
                        errors++;
                        $display("FAIL strobe cyc %0d got v %b addr %h data %h busy %b want v 1 addr %h data %h busy 1",
                                 cyc, mm_write_v_o, mm_write_addr_o, mm_write_data_o, busy_o, e.addr, e.data);
                    end
                end
            end
            exp_here = dq.size() > 0 && dq[0].c == cyc;
            if (done_o != '0 || exp_here) begin
                checks++;
                if (!exp_here) begin
                    errors++;
                    $display("FAIL done_unexpected cyc %0d got %b want 0", cyc, done_o);
                end else begin
                    e = dq.pop_front();
                    want = '0; want[e.idx] = 1'b1;
                    if (done_o !== want || timeout_o !== e.to || busy_o !== 1'b1 ||
                        mm_write_addr_o !== e.addr || mm_write_data_o !== e.data) begin
                        errors++;
                        $display("FAIL done cyc %0d got %b to %b addr %h data %h want %b to %b addr %h data %h",
                                 cyc, done_o, timeout_o, mm_write_addr_o, mm_write_data_o,
                                 want, e.to, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim_time_limit cyc %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        point_t a;
        reset_i       = 1'b1;
        req_v_i       = '0;
        req_addr_i    = '0;
        req_data_i    = '0;
        mm_is_ready_i = 1'b0;
        for (int i = 0; i < N; i++) gcyc[i] = -10;
        model_reset();
        step(1'b0, 1'b1);
        do_reset();

        // Single request from requester 1, ready held high.
        a.x = 5'd5; a.y = 5'd10;
        raise(1, a, 16'h0F00);
        for (int t = 0; t < 6; t++) step(1'b1, 1'b0);
        drain();

        // All requesters continuously out of reset.
        do_reset();
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) raise(i, rnd_addr(), rnd_data());
            step(1'b1, 1'b0);
        end
        drain();

        // Ready high during the strobe (ignored), low 6 wait cycles, then high.
        raise(0, rnd_addr(), rnd_data());
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int t = 0; t < 6; t++) step(1'b0, 1'b0);
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0);
        drain();

        // Ready stuck low: forced completion, sticky flag, then normal service.
        raise(2, rnd_addr(), rnd_data());
        for (int t = 0; t < TO + 6; t++) step(1'b0, 1'b0);
        raise(1, rnd_addr(), rnd_data());
        for (int t = 0; t < 8; t++) step(1'b1, 1'b0);
        drain();

        // Reset during eWait: no done, next grant goes to requester 0.
        raise(2, rnd_addr(), rnd_data());
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        do_reset();
        for (int i = N - 1; i >= 0; i--) raise(i, rnd_addr(), rnd_data());
        for (int t = 0; t < 6; t++) step(1'b1, 1'b0);
        drain();

        // Randomised traffic with periodic long ready-low stretches.
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 2) == 0) raise(i, rnd_addr(), rnd_data());
            step((t % 200 >= 180) ? 1'b0 : ($urandom_range(0, 3) != 0), 1'b0);
        end
        pend = '0;
        drain();
        drain();

        checks++;
        if (gq.size() != 0 || wq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL leftover_events got g %0d w %0d d %0d want 0 0 0", gq.size(), wq.size(), dq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
